micro_core: RTL and testbench

- Parametrised successor to the team's first fetch/execute reader.
- Multi-cycle, accumulator-free micro-sequencer: fetches 2-word instructions from an internal word RAM, reads operands, executes against a register file.
- RAM is loaded by a host port while the core is idle or halted, instead of a hard-coded init sequence.
- Adds subtract, jumps, conditional branch, halt, illegal-opcode trap, retired-instruction counter and a debug RAM read port.

---
 rtl/micro_core_pkg.sv | 34 +++
 rtl/micro_core_regfile.sv | 41 ++++
 rtl/micro_core.sv | 212 +++++++++++++++++++++
 tb/tb_micro_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_core_pkg.sv
// micro_core_pkg: shared definitions for the micro_core sequencer.
//   - opcode constants OP_NOP..OP_HALT (anything above OP_HALT is illegal)
//   - state_t: sequencer state encoding
//   - OPC_HI/OPC_LO: opcode field position inside instruction word0
package micro_core_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 8;

  localparam logic [7:0] OP_NOP  = 8'd0;
  localparam logic [7:0] OP_MOVI = 8'd1;
  localparam logic [7:0] OP_LD   = 8'd2;
  localparam logic [7:0] OP_ST   = 8'd3;
  localparam logic [7:0] OP_ADD  = 8'd4;
  localparam logic [7:0] OP_SUB  = 8'd5;
  localparam logic [7:0] OP_JMP  = 8'd6;
  localparam logic [7:0] OP_JZ   = 8'd7;
  localparam logic [7:0] OP_HALT = 8'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPER,
    S_READ,
    S_EXEC,
    S_HALT
  } state_t;

  // Opcodes are dense from 0, so legality is a single compare.
  function automatic logic is_legal(input logic [7:0] op);
    return (op <= OP_HALT);
  endfunction

endpackage

// File: rtl/micro_core_regfile.sv
// micro_core_regfile: NUM_REGS x DATA_W register file.
//   clk, reset      : clock, asynchronous active-high clear of all entries
//   we/waddr/wdata  : synchronous write port
//   raddr_a/rdata_a : asynchronous read port A
//   raddr_b/rdata_b : asynchronous read port B
//   reg0/reg1       : direct taps of entries 0 and 1 (for the core's r0/r1 mirrors)
module micro_core_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1
);

  // Packed storage so the whole file clears with a single assignment.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign reg0    = regs[0];
  assign reg1    = regs[1];

endmodule

// File: rtl/micro_core.sv
// micro_core: multi-cycle micro-sequencer. Each instruction takes exactly
// four cycles (FETCH, OPER, READ, EXEC) fetching two words from an internal
// RAM and executing against a register file.
// Ports:
//   clk, reset            : clock (rising), asynchronous active-high reset
//   start                 : pulse; starts execution at pc=0 from IDLE/HALT
//   load_we/addr/data     : host RAM write port, honoured only in IDLE/HALT
//   dbg_addr / dbg_data   : debug RAM read, registered, 1-cycle latency
//   pc, opcode            : instruction pointer, opcode of instruction in flight
//   r0, r1                : registered mirrors of register-file entries 0 and 1
//   running/halted/error  : status; error marks a halt caused by an illegal opcode
//   instr_count           : saturating retired-instruction counter
module micro_core
  import micro_core_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAM_DEPTH = 64,
  parameter int NUM_REGS  = 16,
  parameter int CNT_W     = 16,
  localparam int ADDR_W   = $clog2(RAM_DEPTH),
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic              running,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  instr_count
);

  state_t              state;
  logic [REG_AW-1:0]   rd;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   mem_val;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;

  logic [DATA_W-1:0]   ram [RAM_DEPTH];

  logic [ADDR_W-1:0]   op_addr;
  logic [REG_AW-1:0]   rs;
  logic                host_ok;

  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   rf_rdata_a;
  logic [DATA_W-1:0]   rf_rdata_b;
  logic [DATA_W-1:0]   rf_reg0;
  logic [DATA_W-1:0]   rf_reg1;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;

  assign op_addr = operand[ADDR_W-1:0];
  assign rs      = operand[REG_AW-1:0];
  assign host_ok = (state == S_IDLE) || (state == S_HALT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  micro_core_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .raddr_a (rd),
    .rdata_a (rf_rdata_a),
    .raddr_b (rs),
    .rdata_b (rf_rdata_b),
    .reg0    (rf_reg0),
    .reg1    (rf_reg1)
  );

  // Write steering. Host loads and ST are in disjoint states, so the single
  // RAM write port never sees both at once.
  always_comb begin
    rf_we     = 1'b0;
    rf_wdata  = operand;
    ram_we    = 1'b0;
    ram_waddr = load_addr;
    ram_wdata = load_data;
    if (state == S_EXEC) begin
      case (opcode)
        OP_MOVI: begin rf_we = 1'b1; rf_wdata = operand;         end
        OP_LD:   begin rf_we = 1'b1; rf_wdata = mem_val;         end
        OP_ADD:  begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
        OP_SUB:  begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
        OP_ST: begin
          ram_we    = 1'b1;
          ram_waddr = op_addr;
          ram_wdata = rd_val;
        end
        default: ;
      endcase
    end else if (host_ok && load_we) begin
      ram_we = 1'b1;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_data <= '0;
      r0       <= '0;
      r1       <= '0;
    end else begin
      dbg_data <= ram[dbg_addr];
      r0       <= rf_reg0;
      r1       <= rf_reg1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      opcode      <= '0;
      rd          <= '0;
      operand     <= '0;
      mem_val     <= '0;
      rd_val      <= '0;
      rs_val      <= '0;
      running     <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= '0;
            error       <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            running     <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          opcode <= ram[pc][OPC_HI:OPC_LO];
          rd     <= ram[pc][REG_AW-1:0];
          state  <= S_OPER;
        end
        S_OPER: begin
          // pc+1 wraps naturally, so an instruction at the last word is legal.
          operand <= ram[pc + ADDR_W'(1)];
          state   <= S_READ;
        end
        S_READ: begin
          // All operands are snapshotted here, so ADD rd,rd sees the old rd twice.
          mem_val <= ram[op_addr];
          rd_val  <= rf_rdata_a;
          rs_val  <= rf_rdata_b;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (!is_legal(opcode)) begin
            error   <= 1'b1;
            halted  <= 1'b1;
            running <= 1'b0;
            state   <= S_HALT;
          end else begin
            instr_count <= sat_inc(instr_count);
            case (opcode)
              OP_HALT: begin
                halted  <= 1'b1;
                running <= 1'b0;
                state   <= S_HALT;
              end
              OP_JMP: begin
                pc    <= op_addr;
                state <= S_FETCH;
              end
              OP_JZ: begin
                pc    <= (rd_val == '0) ? op_addr : pc + ADDR_W'(2);
                state <= S_FETCH;
              end
              default: begin
                pc    <= pc + ADDR_W'(2);
                state <= S_FETCH;
              end
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_core.sv
module tb_micro_core;
  import micro_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        load_we = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [5:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [5:0]  pc;
  logic [7:0]  opcode;
  logic [15:0] r0, r1;
  logic        running, halted, error;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] cnt;
    logic [5:0]  pc;
    logic        err;
  } run_exp_t;

  run_exp_t    run_q[$];
  logic [15:0] dbg_q[$];
  logic [15:0] img[64];

  micro_core #(
    .DATA_W(16), .RAM_DEPTH(64), .NUM_REGS(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .opcode(opcode), .r0(r0), .r1(r1),
    .running(running), .halted(halted), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [7:0] op, input logic [3:0] r);
    return {op, 4'h0, r};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 16'h0000;
  endtask

  task automatic load_image();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = 6'(i); load_data = img[i];
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(output int n, output bit ok);
    n = 0;
    while (halted !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = (halted === 1'b1);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    checks++; if (pc !== 6'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (opcode !== 8'd0) begin failures++; $display("FAIL reset_opcode got=%0d exp=0", opcode); end
    checks++; if (r0 !== 16'd0 || r1 !== 16'd0) begin failures++; $display("FAIL reset_regs got r0=%h r1=%h exp=0", r0, r1); end
    checks++; if (dbg_data !== 16'd0) begin failures++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    checks++; if ({running, halted, error} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {running, halted, error}); end
    checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sum();
    run_exp_t e; int n; bit ok; logic [15:0] d;
    clear_img();
    img[0] = ins(OP_LD, 0);   img[1] = 16'd16;
    img[2] = ins(OP_LD, 1);   img[3] = 16'd17;
    img[4] = ins(OP_ADD, 0);  img[5] = 16'd1;
    img[6] = ins(OP_ST, 0);   img[7] = 16'd18;
    img[8] = ins(OP_HALT, 0); img[9] = 16'd0;
    img[16] = 16'd5; img[17] = 16'd7;
    load_image();
    run_q.push_back('{r0: 16'd12, r1: 16'd7, cnt: 16'd5, pc: 6'd8, err: 1'b0});
    pulse_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL sum_running got=%b exp=1", running); end
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL sum_timeout got halted=%b exp=1", halted); end
    checks++; if (n != 20) begin failures++; $display("FAIL sum_cycles got=%0d exp=20", n); end
    checks++; if (error !== e.err || running !== 1'b0) begin failures++; $display("FAIL sum_status got err=%b run=%b exp err=%b run=0", error, running, e.err); end
    checks++; if (r0 !== e.r0 || r1 !== e.r1) begin failures++; $display("FAIL sum_regs got r0=%h r1=%h exp r0=%h r1=%h", r0, r1, e.r0, e.r1); end
    checks++; if (instr_count !== e.cnt) begin failures++; $display("FAIL sum_count got=%0d exp=%0d", instr_count, e.cnt); end
    checks++; if (pc !== e.pc) begin failures++; $display("FAIL sum_pc got=%0d exp=%0d", pc, e.pc); end
    dbg_q.push_back(16'd12); dbg_addr = 6'd18;
    @(negedge clk);
    d = dbg_q.pop_front();
    checks++; if (dbg_data !== d) begin failures++; $display("FAIL sum_dbg18 got=%h exp=%h", dbg_data, d); end
  endtask

  task automatic test_overflow_sub();
    run_exp_t e; int n; bit ok; logic [15:0] d;
    clear_img();
    img[0]  = ins(OP_MOVI, 2); img[1]  = 16'hFFFF;
    img[2]  = ins(OP_MOVI, 3); img[3]  = 16'h0001;
    img[4]  = ins(OP_ADD, 2);  img[5]  = 16'd3;
    img[6]  = ins(OP_SUB, 3);  img[7]  = 16'd2;
    img[8]  = ins(OP_MOVI, 0); img[9]  = 16'h0000;
    img[10] = ins(OP_SUB, 0);  img[11] = 16'd3;
    img[12] = ins(OP_ST, 2);   img[13] = 16'd40;
    img[14] = ins(OP_ST, 3);   img[15] = 16'd41;
    img[16] = ins(OP_HALT, 0);
    load_image();
    run_q.push_back('{r0: 16'hFFFF, r1: 16'd7, cnt: 16'd9, pc: 6'd16, err: 1'b0});
    pulse_start();
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got halted=%b exp=1", halted); end
    checks++; if (r0 !== e.r0 || r1 !== e.r1) begin failures++; $display("FAIL ovf_regs got r0=%h r1=%h exp r0=%h r1=%h", r0, r1, e.r0, e.r1); end
    checks++; if (instr_count !== e.cnt || pc !== e.pc) begin failures++; $display("FAIL ovf_cnt_pc got cnt=%0d pc=%0d exp cnt=%0d pc=%0d", instr_count, pc, e.cnt, e.pc); end
    for (int i = 0; i < 2; i++) begin
      dbg_q.push_back(i == 0 ? 16'h0000 : 16'h0001);
      dbg_addr = 6'(40 + i);
      @(negedge clk);
      d = dbg_q.pop_front();
      checks++; if (dbg_data !== d) begin failures++; $display("FAIL ovf_reg%0d got=%h exp=%h", i + 2, dbg_data, d); end
    end
  endtask

  task automatic test_branch_loop();
    run_exp_t e; int n; bit ok;
    clear_img();
    img[0]  = ins(OP_MOVI, 1); img[1]  = 16'd3;
    img[2]  = ins(OP_MOVI, 4); img[3]  = 16'd1;
    img[4]  = ins(OP_SUB, 1);  img[5]  = 16'd4;
    img[6]  = ins(OP_JZ, 1);   img[7]  = 16'd10;
    img[8]  = ins(OP_JMP, 0);  img[9]  = 16'd4;
    img[10] = ins(OP_HALT, 0);
    load_image();
    run_q.push_back('{r0: 16'hFFFF, r1: 16'd0, cnt: 16'd11, pc: 6'd10, err: 1'b0});
    pulse_start();
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL loop_timeout got halted=%b exp=1", halted); end
    checks++; if (r0 !== e.r0 || r1 !== e.r1) begin failures++; $display("FAIL loop_regs got r0=%h r1=%h exp r0=%h r1=%h", r0, r1, e.r0, e.r1); end
    checks++; if (instr_count !== e.cnt || pc !== e.pc || error !== e.err) begin failures++; $display("FAIL loop_state got cnt=%0d pc=%0d err=%b exp cnt=%0d pc=%0d err=%b", instr_count, pc, error, e.cnt, e.pc, e.err); end
  endtask

  task automatic test_illegal();
    run_exp_t e; int n; bit ok;
    clear_img();
    img[0] = 16'h2A00;
    load_image();
    run_q.push_back('{r0: 16'hFFFF, r1: 16'd0, cnt: 16'd0, pc: 6'd0, err: 1'b1});
    pulse_start();
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL ill_timeout got halted=%b exp=1", halted); end
    checks++; if (error !== e.err || running !== 1'b0) begin failures++; $display("FAIL ill_error got err=%b run=%b exp err=%b run=0", error, running, e.err); end
    checks++; if (instr_count !== e.cnt || pc !== e.pc) begin failures++; $display("FAIL ill_cnt_pc got cnt=%0d pc=%0d exp cnt=%0d pc=%0d", instr_count, pc, e.cnt, e.pc); end
    img[0] = ins(OP_HALT, 0);
    load_image();
    run_q.push_back('{r0: 16'hFFFF, r1: 16'd0, cnt: 16'd1, pc: 6'd0, err: 1'b0});
    pulse_start();
    checks++; if (error !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL ill_restart_clear got err=%b hlt=%b exp 0 0", error, halted); end
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok || error !== e.err || instr_count !== e.cnt) begin failures++; $display("FAIL ill_rerun got hlt=%b err=%b cnt=%0d exp hlt=1 err=%b cnt=%0d", halted, error, instr_count, e.err, e.cnt); end
  endtask

  task automatic test_pc_wrap();
    run_exp_t e; int n; bit ok; logic [15:0] d;
    clear_img();
    img[0]  = ins(OP_MOVI, 5); img[1] = ins(OP_HALT, 0);
    img[2]  = ins(OP_ST, 5);   img[3] = 16'd0;
    img[4]  = ins(OP_JMP, 0);  img[5] = 16'd62;
    img[62] = ins(OP_NOP, 0);  img[63] = 16'd0;
    load_image();
    run_q.push_back('{r0: 16'hFFFF, r1: 16'd0, cnt: 16'd5, pc: 6'd0, err: 1'b0});
    pulse_start();
    load_we = 1'b1; load_addr = 6'd40; load_data = 16'hBEEF;
    @(negedge clk);
    load_we = 1'b0;
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got halted=%b exp=1", halted); end
    checks++; if (pc !== e.pc || instr_count !== e.cnt || error !== e.err) begin failures++; $display("FAIL wrap_state got pc=%0d cnt=%0d err=%b exp pc=%0d cnt=%0d err=%b", pc, instr_count, error, e.pc, e.cnt, e.err); end
    dbg_q.push_back(16'h0000); dbg_addr = 6'd40;
    @(negedge clk);
    d = dbg_q.pop_front();
    checks++; if (dbg_data !== d) begin failures++; $display("FAIL wrap_load_blocked got=%h exp=%h", dbg_data, d); end
    dbg_q.push_back(ins(OP_HALT, 0)); dbg_addr = 6'd0;
    @(negedge clk);
    d = dbg_q.pop_front();
    checks++; if (dbg_data !== d) begin failures++; $display("FAIL wrap_selfmod got=%h exp=%h", dbg_data, d); end
  endtask

  task automatic test_reset_mid_exec();
    run_exp_t e; int n; bit ok;
    clear_img();
    img[0] = ins(OP_MOVI, 0); img[1] = 16'h0055;
    img[2] = ins(OP_HALT, 0);
    load_image();
    pulse_start();
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (pc !== 6'd0 || opcode !== 8'd0 || instr_count !== 16'd0) begin failures++; $display("FAIL mid_reset_ctl got pc=%0d op=%0d cnt=%0d exp 0 0 0", pc, opcode, instr_count); end
    checks++; if ({running, halted, error} !== 3'b000 || r0 !== 16'd0 || dbg_data !== 16'd0) begin failures++; $display("FAIL mid_reset_out got st=%b r0=%h dbg=%h exp 000 0 0", {running, halted, error}, r0, dbg_data); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (r0 !== 16'd0 || running !== 1'b0) begin failures++; $display("FAIL mid_reset_nowrite got r0=%h run=%b exp r0=0 run=0", r0, running); end
    run_q.push_back('{r0: 16'h0055, r1: 16'd0, cnt: 16'd2, pc: 6'd2, err: 1'b0});
    pulse_start();
    wait_halt(n, ok);
    e = run_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL mid_rerun_timeout got halted=%b exp=1", halted); end
    checks++; if (r0 !== e.r0 || r1 !== e.r1 || instr_count !== e.cnt || pc !== e.pc) begin failures++; $display("FAIL mid_rerun got r0=%h r1=%h cnt=%0d pc=%0d exp r0=%h r1=%h cnt=%0d pc=%0d", r0, r1, instr_count, pc, e.r0, e.r1, e.cnt, e.pc); end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_overflow_sub();
    test_branch_loop();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
